memory_bus_arbiter: RTL

Shares the single 128-bit block port of main memory between the instruction cache (read-only) and the data cache (read/write) in the RV32IM pipeline. It grants one cache at a time and latches the request for the whole memory transaction. It returns read data and releases busywait only to the granted cache. Ties are broken round-robin so neither cache starves during refill/write-back storms.

---
 rtl/mem_bus_pkg.sv | 18 +
 rtl/rr_priority_2.sv | 23 ++
 rtl/memory_bus_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the instruction/data cache memory bus arbiter:
// FSM state encoding, default bus widths and grant identifiers.
package mem_bus_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 28;
    localparam int unsigned DATA_WIDTH_DEF = 128;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT_I,
        ST_GRANT_D,
        ST_RELEASE
    } arb_state_t;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/rr_priority_2.sv
// Two-requester round-robin picker: the requester that did not win last
// time gets priority on a tie. Grant is one-hot, bit 0 = icache, bit 1 = dcache.
module rr_priority_2
    import mem_bus_pkg::*;
(
    input  logic       i_req_i,
    input  logic       i_req_d,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        if (i_req_i && i_req_d) begin
            o_grant = (i_last_grant == GNT_I) ? 2'b10 : 2'b01;
        end else if (i_req_i) begin
            o_grant = 2'b01;
        end else if (i_req_d) begin
            o_grant = 2'b10;
        end
    end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Arbitrates the single main-memory block port between icache (read-only)
// and dcache (read/write), holding the latched request for a whole transaction.
module memory_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  I_MEM_READ,
    input  logic [ADDR_WIDTH-1:0] I_MEM_ADDRESS,
    output logic [DATA_WIDTH-1:0] I_MEM_READ_DATA,
    output logic                  I_MEM_BUSY_WAIT,
    input  logic                  D_MEM_READ,
    input  logic                  D_MEM_WRITE,
    input  logic [ADDR_WIDTH-1:0] D_MEM_ADDRESS,
    input  logic [DATA_WIDTH-1:0] D_MEM_WRITE_DATA,
    output logic [DATA_WIDTH-1:0] D_MEM_READ_DATA,
    output logic                  D_MEM_BUSY_WAIT,
    output logic                  MAIN_MEM_READ,
    output logic                  MAIN_MEM_WRITE,
    output logic [ADDR_WIDTH-1:0] MAIN_MEM_ADDRESS,
    output logic [DATA_WIDTH-1:0] MAIN_MEM_WRITE_DATA,
    input  logic [DATA_WIDTH-1:0] MAIN_MEM_READ_DATA,
    input  logic                  MAIN_MEM_BUSY_WAIT
);

    arb_state_t            r_state;
    arb_state_t            w_state_next;
    logic                  r_last_grant;
    logic                  r_started;
    logic                  r_mm_read;
    logic                  r_mm_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_i_rdata;
    logic [DATA_WIDTH-1:0] r_d_rdata;

    logic                  w_i_req;
    logic                  w_d_req;
    logic                  w_granted;
    logic                  w_done;
    logic [1:0]            w_grant;

    assign w_i_req   = I_MEM_READ;
    assign w_d_req   = D_MEM_READ | D_MEM_WRITE;
    assign w_granted = (r_state == ST_GRANT_I) || (r_state == ST_GRANT_D);
    // Memory only counts as finished once it has acknowledged with busy-high.
    assign w_done    = w_granted & r_started & ~MAIN_MEM_BUSY_WAIT;

    rr_priority_2 u_rr_priority_2 (
        .i_req_i      (w_i_req),
        .i_req_d      (w_d_req),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant[1]) begin
                    w_state_next = ST_GRANT_D;
                end else if (w_grant[0]) begin
                    w_state_next = ST_GRANT_I;
                end
            end
            ST_GRANT_I, ST_GRANT_D: begin
                if (w_done) begin
                    w_state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last_grant <= GNT_I;
            r_started    <= 1'b0;
            r_mm_read    <= 1'b0;
            r_mm_write   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
        end else begin
            if (r_state == ST_IDLE && w_grant != 2'b00) begin
                r_started <= 1'b0;
                if (w_grant[1]) begin
                    r_last_grant <= GNT_D;
                    r_addr       <= D_MEM_ADDRESS;
                    r_wdata      <= D_MEM_WRITE_DATA;
                    r_mm_write   <= D_MEM_WRITE;
                    r_mm_read    <= ~D_MEM_WRITE;
                end else begin
                    r_last_grant <= GNT_I;
                    r_addr       <= I_MEM_ADDRESS;
                    r_mm_write   <= 1'b0;
                    r_mm_read    <= 1'b1;
                end
            end
            if (w_granted && MAIN_MEM_BUSY_WAIT) begin
                r_started <= 1'b1;
            end
            if (w_done) begin
                r_mm_read  <= 1'b0;
                r_mm_write <= 1'b0;
                if (r_state == ST_GRANT_I) begin
                    r_i_rdata <= MAIN_MEM_READ_DATA;
                end else if (!r_mm_write) begin
                    r_d_rdata <= MAIN_MEM_READ_DATA;
                end
            end
        end
    end

    always_comb begin
        MAIN_MEM_READ       = r_mm_read;
        MAIN_MEM_WRITE      = r_mm_write;
        MAIN_MEM_ADDRESS    = r_addr;
        MAIN_MEM_WRITE_DATA = r_wdata;
        I_MEM_BUSY_WAIT     = w_i_req & ~((r_state == ST_GRANT_I) & w_done);
        D_MEM_BUSY_WAIT     = w_d_req & ~((r_state == ST_GRANT_D) & w_done);
        I_MEM_READ_DATA     = (r_state == ST_GRANT_I) ? MAIN_MEM_READ_DATA : r_i_rdata;
        D_MEM_READ_DATA     = (r_state == ST_GRANT_D) ? MAIN_MEM_READ_DATA : r_d_rdata;
    end

endmodule
